ahb_bridge_arbiter: RTL and testbench
=====================================

Name: ahb_bridge_arbiter

Overview:
- Round-robin arbiter sharing the single AHB-to-APB bridge between NUM_MASTERS AHB requesters.
- Grants one master at a time for a fixed-length burst. Beats are counted on bridge-accepted transfers (valid && Hreadyout).
- Supports locked back-to-back bursts, with a starvation cap.
- Sits between the requesters' Hbusreq/Hlock lines and the bridge's address/data mux select (Hmaster).

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
MW, 2, width of Hmaster; must equal clog2(NUM_MASTERS)
LEN_W, 4, width of per-master burst length field (beats-1)
LOCK_MAX, 3, max consecutive locked bursts by one master before forced handover

Ports:
Hclk  in  1  clock
Hreset  in  1  synchronous active-high reset
Hbusreq  in  NUM_MASTERS  per-master bus request
Hlock  in  NUM_MASTERS  per-master lock request, sampled with Hbusreq
Hburstlen  in  NUM_MASTERS*LEN_W  per-master burst length minus one; master i at bits [i*LEN_W +: LEN_W]
valid  in  1  granted master's transfer valid, from the bridge slave interface
Hreadyout  in  1  bridge ready; a beat completes when valid && Hreadyout
Hgrant  out  NUM_MASTERS  one-hot grant, registered
Hmaster  out  MW  index of granted master; holds last owner when Hgrant==0
Hmastlock  out  1  current burst is locked
arb_busy  out  1  high in ST_GRANT and ST_BURST

Behaviour:
- Reset state: state=ST_IDLE, Hgrant=0, Hmaster=0, Hmastlock=0, arb_busy=0, beat counter=0, lock counter=0.
- Reset: Hreset asserted mid-burst returns to these values on the next edge. The in-flight beat is abandoned.
- Round-robin pointer: ptr=0 at reset.
  - The winner is the first i with Hbusreq[i] set, searching ptr, ptr+1, ... modulo NUM_MASTERS.
  - On each new grant, ptr = winner+1 (wraps to 0).
- ST_IDLE:
  - If any Hbusreq is set: register Hgrant=onehot(winner) and Hmaster=winner.
  - Load beat_cnt = Hburstlen[winner]. Set Hmastlock = Hlock[winner] and lock_cnt=0. Go to ST_GRANT.
  - Grant latency: request sampled at edge n, Hgrant visible after edge n.
  - Otherwise stay in ST_IDLE with Hgrant=0.
- ST_GRANT (waiting for the first beat):
  - valid && Hreadyout: if beat_cnt==0, perform burst-end handling; else decrement beat_cnt and go to ST_BURST.
  - Hbusreq[Hmaster]==0 with no beat: go to ST_HANDOVER (request withdrawn).
- ST_BURST:
  - Each valid && Hreadyout beat decrements beat_cnt.
  - Hreadyout low: hold, with no count change.
  - The beat with beat_cnt==0 triggers burst-end handling.
  - Deassertion of Hbusreq mid-burst is ignored; the burst runs to completion.
- Burst-end handling:
  - Condition for a re-grant: Hlock[Hmaster] && Hbusreq[Hmaster] && lock_cnt < LOCK_MAX-1.
  - If true: reload beat_cnt = Hburstlen[Hmaster], increment lock_cnt, keep Hgrant and Hmastlock=1, go to ST_GRANT. ptr is not updated.
  - Otherwise: Hgrant=0, Hmastlock=0, go to ST_HANDOVER.
- ST_HANDOVER:
  - Exactly one cycle with Hgrant=0, letting the bridge drain its enable phase.
  - Next state is ST_IDLE. Arbitration occurs there, so the minimum gap between owners is 2 cycles with Hgrant=0 (HANDOVER plus IDLE).
- Simultaneous events:
  - A beat on the same cycle Hbusreq drops in ST_GRANT counts as a beat; the beat wins over the withdrawal.
  - New requests arriving during a burst wait for ST_IDLE.
- Hburstlen=0 gives a single-beat burst that ends on its first beat.
- Forced handover: when lock_cnt reaches LOCK_MAX-1, the next burst end always hands over, even if Hlock is held.
- Invariants: Hgrant is always one-hot or zero. Hmaster changes only on entry to ST_GRANT from ST_IDLE.

Test Plan:
- Reset then Hbusreq=4'b0100, Hburstlen[2]=3, valid=Hreadyout=1 continuously -> Hgrant=4'b0100 one cycle after request. Four beats complete, then ST_HANDOVER, then Hgrant=0.
- Hbusreq=4'b1111 held, all Hburstlen=0, Hlock=0 -> grant order 0,1,2,3,0. Two Hgrant=0 cycles between owners.
- Master 1 with Hlock=1, Hbusreq held, Hburstlen=1, LOCK_MAX=3; master 3 also requesting -> master 1 owns 3 bursts (6 beats) with Hmastlock=1, then master 3 is granted.
- Grant master 0 with Hburstlen=2; drive Hreadyout=0 for 5 cycles mid-burst -> beat_cnt holds. The burst ends only after 3 accepted beats.
- Grant master 2, then drop Hbusreq[2] before any beat -> ST_HANDOVER next edge, Hgrant=0. Pending master 3 is granted 2 cycles later.
- Assert Hreset mid-burst -> next edge: Hgrant=0, Hmaster=0, arb_busy=0. ptr=0, so with all masters requesting, master 0 is granted first after release.

Source files
------------

// File: rtl/ahb_bridge_arbiter_if.sv
// Bus bundle between the AHB requesters / bridge and the bridge arbiter.
// The "slave" modport is the arbiter's view; "master" is the view of the
// requesters and the bridge that drive requests and consume the grant.
interface ahb_bridge_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2,
    parameter int LEN_W       = 4
);
    logic [NUM_MASTERS-1:0]       Hbusreq;
    logic [NUM_MASTERS-1:0]       Hlock;
    logic [NUM_MASTERS*LEN_W-1:0] Hburstlen;
    logic                         valid;
    logic                         Hreadyout;
    logic [NUM_MASTERS-1:0]       Hgrant;
    logic [MW-1:0]                Hmaster;
    logic                         Hmastlock;
    logic                         arb_busy;

    modport slave (
        input  Hbusreq, Hlock, Hburstlen, valid, Hreadyout,
        output Hgrant, Hmaster, Hmastlock, arb_busy
    );

    modport master (
        output Hbusreq, Hlock, Hburstlen, valid, Hreadyout,
        input  Hgrant, Hmaster, Hmastlock, arb_busy
    );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge between NUM_MASTERS
// requesters. One owner at a time holds the bridge for a fixed-length burst;
// locked owners may chain bursts up to LOCK_MAX before a forced handover.
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2,
    parameter int LEN_W       = 4,
    parameter int LOCK_MAX    = 3
) (
    input logic                 Hclk,
    input logic                 Hreset,
    ahb_bridge_arbiter_if.slave bus
);

    // Lock counter only ever reaches LOCK_MAX-1.
    localparam int LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT    = 2'd1;
    localparam logic [1:0] ST_BURST    = 2'd2;
    localparam logic [1:0] ST_HANDOVER = 2'd3;

    logic [1:0]             state_q,    state_d;
    logic [NUM_MASTERS-1:0] grant_q,    grant_d;
    logic [MW-1:0]          master_q,   master_d;
    logic                   mastlock_q, mastlock_d;
    logic [LEN_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [MW-1:0]          ptr_q,      ptr_d;

    logic [LEN_W-1:0]       len_arr [NUM_MASTERS];
    logic                   win_found;
    logic [MW-1:0]          win_idx;
    logic [MW-1:0]          ptr_next;
    logic                   beat;
    logic                   in_burst;
    logic                   end_burst;
    logic                   regrant;

    // Split the packed burst-length bus into one field per master.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            len_arr[i] = bus.Hburstlen[i*LEN_W +: LEN_W];
        end
    end

    // Round-robin search: first requester at or after ptr, modulo NUM_MASTERS.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_MASTERS;
            if (!win_found && bus.Hbusreq[idx]) begin
                win_found = 1'b1;
                win_idx   = MW'(idx);
            end
        end
        ptr_next = (win_idx == MW'(NUM_MASTERS - 1)) ? '0 : win_idx + MW'(1);
    end

    // Beat and burst-end qualifiers shared by the state machine.
    always_comb begin
        beat      = bus.valid && bus.Hreadyout;
        in_burst  = (state_q == ST_GRANT) || (state_q == ST_BURST);
        end_burst = in_burst && beat && (beat_cnt_q == '0);
        regrant   = bus.Hlock[master_q] && bus.Hbusreq[master_q] &&
                    (lock_cnt_q < LOCK_LAST);
    end

    // Next-state and next-register computation for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        beat_cnt_d = beat_cnt_q;
        lock_cnt_d = lock_cnt_q;
        ptr_d      = ptr_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    master_d         = win_idx;
                    beat_cnt_d       = len_arr[win_idx];
                    mastlock_d       = bus.Hlock[win_idx];
                    lock_cnt_d       = '0;
                    ptr_d            = ptr_next;
                    state_d          = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // A beat on the same cycle as a withdrawn request still counts.
                if (beat) begin
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                        state_d    = ST_BURST;
                    end
                end else if (!bus.Hbusreq[master_q]) begin
                    grant_d    = '0;
                    mastlock_d = 1'b0;
                    state_d    = ST_HANDOVER;
                end
            end

            ST_BURST: begin
                // Request deassertion is ignored here; the burst always completes.
                if (beat && (beat_cnt_q != '0)) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                end
            end

            ST_HANDOVER: begin
                // One dead cycle so the bridge can drain its enable phase.
                grant_d = '0;
                state_d = ST_IDLE;
            end

            default: begin
                grant_d    = '0;
                mastlock_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // Last beat of a burst: chain another locked burst or hand the bridge over.
        if (end_burst) begin
            if (regrant) begin
                beat_cnt_d = len_arr[master_q];
                lock_cnt_d = lock_cnt_q + LCW'(1);
                mastlock_d = 1'b1;
                state_d    = ST_GRANT;
            end else begin
                grant_d    = '0;
                mastlock_d = 1'b0;
                state_d    = ST_HANDOVER;
            end
        end
    end

    // Register update with synchronous reset; an in-flight beat is abandoned.
    always_ff @(posedge Hclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (Hreset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            master_q   <= '0;
            mastlock_q <= 1'b0;
            beat_cnt_q <= '0;
            lock_cnt_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            beat_cnt_q <= beat_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.Hgrant    = grant_q;
    assign bus.Hmaster   = master_q;
    assign bus.Hmastlock = mastlock_q;
    assign bus.arb_busy  = (state_q == ST_GRANT) || (state_q == ST_BURST);

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter. Stimulus pushes the expected owner of
// each new grant into a queue; a monitor pops and compares on every new grant.
module tb_ahb_bridge_arbiter;

    typedef struct packed {
        logic [1:0] m;
        logic       lock;
    } exp_t;

    logic clk = 1'b0;
    logic Hreset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t       exp_q[$];
    exp_t       sb_e;
    logic [3:0] prev_grant = '0;

    ahb_bridge_arbiter_if #(.NUM_MASTERS(4), .MW(2), .LEN_W(4)) bus ();

    ahb_bridge_arbiter #(
        .NUM_MASTERS(4), .MW(2), .LEN_W(4), .LOCK_MAX(3)
    ) dut (
        .Hclk   (clk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every new non-zero grant must match the queue head.
    always @(negedge clk) begin
        check("grant_onehot0", 32'($onehot0(bus.Hgrant)), 32'd1);
        if (bus.Hgrant != 4'b0 && bus.Hgrant != prev_grant) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", 32'(bus.Hgrant), 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_grant",    32'(bus.Hgrant),    32'(4'b0001 << sb_e.m));
                check("sb_master",   32'(bus.Hmaster),   32'(sb_e.m));
                check("sb_mastlock", 32'(bus.Hmastlock), 32'(sb_e.lock));
            end
        end
        prev_grant = bus.Hgrant;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        Hreset        = 1'b1;
        bus.Hbusreq   = '0;
        bus.Hlock     = '0;
        bus.Hburstlen = '0;
        bus.valid     = 1'b0;
        bus.Hreadyout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant",    32'(bus.Hgrant),    32'd0);
        check("rst_master",   32'(bus.Hmaster),   32'd0);
        check("rst_mastlock", 32'(bus.Hmastlock), 32'd0);
        check("rst_busy",     32'(bus.arb_busy),  32'd0);
        Hreset = 1'b0;
    endtask

    // Wait for the next owner, then measure its idle gap and grant length.
    task automatic observe_owner(output int gap, output int len,
                                 output logic [3:0] g, output logic ml);
        gap = 0;
        while (bus.Hgrant == 4'b0 && gap < 40) begin
            gap++;
            @(negedge clk);
        end
        check("owner_wait_bound", 32'(gap < 40), 32'd1);
        g   = bus.Hgrant;
        ml  = bus.Hmastlock;
        len = 0;
        while (bus.Hgrant == g && g != 4'b0 && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         gap, len;
        logic [3:0] g;
        logic       ml;
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus.Hbusreq   = '0;
        bus.Hlock     = '0;
        bus.Hburstlen = '0;
        bus.valid     = 1'b0;
        bus.Hreadyout = 1'b0;
        @(negedge clk);
        do_reset();

        // Single 4-beat burst from master 2 with continuous beats.
        bus.Hburstlen = 16'h0300;
        bus.valid     = 1'b1;
        bus.Hreadyout = 1'b1;
        bus.Hbusreq   = 4'b0100;
        exp_q.push_back('{m: 2'd2, lock: 1'b0});
        check("t1_no_grant_yet", 32'(bus.Hgrant), 32'd0);
        @(negedge clk);
        check("t1_grant_latency", 32'(bus.Hgrant), 32'b0100);
        check("t1_busy", 32'(bus.arb_busy), 32'd1);
        bus.Hbusreq = 4'b0000;
        len = 0;
        while (bus.Hgrant == 4'b0100 && len < 20) begin
            len++;
            @(negedge clk);
        end
        check("t1_burst_cycles", 32'(len), 32'd4);
        check("t1_handover_grant", 32'(bus.Hgrant), 32'd0);
        check("t1_handover_busy", 32'(bus.arb_busy), 32'd0);
        check("t1_master_holds", 32'(bus.Hmaster), 32'd2);
        @(negedge clk);
        check("t1_idle_grant", 32'(bus.Hgrant), 32'd0);

        // Round robin with all masters requesting single-beat bursts.
        do_reset();
        bus.valid     = 1'b1;
        bus.Hreadyout = 1'b1;
        bus.Hbusreq   = 4'b1111;
        exp_q.push_back('{m: 2'd0, lock: 1'b0});
        exp_q.push_back('{m: 2'd1, lock: 1'b0});
        exp_q.push_back('{m: 2'd2, lock: 1'b0});
        exp_q.push_back('{m: 2'd3, lock: 1'b0});
        exp_q.push_back('{m: 2'd0, lock: 1'b0});
        for (int k = 0; k < 5; k++) begin
            observe_owner(gap, len, g, ml);
            check("t2_order", 32'(g), 32'(order[k]));
            check("t2_len", 32'(len), 32'd1);
            check("t2_lock", 32'(ml), 32'd0);
            if (k > 0) check("t2_gap", 32'(gap), 32'd2);
        end
        bus.Hbusreq = 4'b0000;

        // Locked master 1 chains three 2-beat bursts, then master 3 gets the bus.
        do_reset();
        bus.Hburstlen = 16'h0010;
        bus.Hlock     = 4'b0010;
        bus.valid     = 1'b1;
        bus.Hreadyout = 1'b1;
        bus.Hbusreq   = 4'b1010;
        exp_q.push_back('{m: 2'd1, lock: 1'b1});
        exp_q.push_back('{m: 2'd3, lock: 1'b0});
        observe_owner(gap, len, g, ml);
        check("t3_lock_owner", 32'(g), 32'b0010);
        check("t3_lock_beats", 32'(len), 32'd6);
        check("t3_mastlock", 32'(ml), 32'd1);
        observe_owner(gap, len, g, ml);
        check("t3_next_owner", 32'(g), 32'b1000);
        check("t3_next_gap", 32'(gap), 32'd2);
        check("t3_next_len", 32'(len), 32'd1);
        check("t3_next_mastlock", 32'(ml), 32'd0);
        bus.Hbusreq = 4'b0000;
        bus.Hlock   = 4'b0000;

        // Hreadyout stall mid-burst holds the beat count.
        do_reset();
        bus.Hburstlen = 16'h0002;
        bus.valid     = 1'b1;
        bus.Hreadyout = 1'b1;
        bus.Hbusreq   = 4'b0001;
        exp_q.push_back('{m: 2'd0, lock: 1'b0});
        @(negedge clk);
        check("t4_grant", 32'(bus.Hgrant), 32'b0001);
        @(negedge clk);
        check("t4_after_first_beat", 32'(bus.Hgrant), 32'b0001);
        bus.Hreadyout = 1'b0;
        bus.Hbusreq   = 4'b0000;
        repeat (5) begin
            @(negedge clk);
            check("t4_stall_hold", 32'(bus.Hgrant), 32'b0001);
        end
        bus.Hreadyout = 1'b1;
        @(negedge clk);
        check("t4_one_beat_left", 32'(bus.Hgrant), 32'b0001);
        @(negedge clk);
        check("t4_burst_done", 32'(bus.Hgrant), 32'd0);
        check("t4_busy_done", 32'(bus.arb_busy), 32'd0);

        // Request withdrawn before the first beat; pending master 3 follows.
        do_reset();
        bus.Hburstlen = 16'h0300;
        bus.valid     = 1'b0;
        bus.Hreadyout = 1'b1;
        bus.Hbusreq   = 4'b1100;
        exp_q.push_back('{m: 2'd2, lock: 1'b0});
        exp_q.push_back('{m: 2'd3, lock: 1'b0});
        @(negedge clk);
        check("t5_grant2", 32'(bus.Hgrant), 32'b0100);
        bus.Hbusreq = 4'b1000;
        @(negedge clk);
        check("t5_withdraw_grant", 32'(bus.Hgrant), 32'd0);
        check("t5_withdraw_busy", 32'(bus.arb_busy), 32'd0);
        @(negedge clk);
        check("t5_idle_gap", 32'(bus.Hgrant), 32'd0);
        @(negedge clk);
        check("t5_grant3", 32'(bus.Hgrant), 32'b1000);
        check("t5_master3", 32'(bus.Hmaster), 32'd3);
        bus.valid = 1'b1;
        @(negedge clk);
        check("t5_single_beat_end", 32'(bus.Hgrant), 32'd0);
        bus.Hbusreq = 4'b0000;
        bus.valid   = 1'b0;
        @(negedge clk);
        // Beat on the same cycle the request drops: the beat wins.
        bus.Hburstlen = 16'h0010;
        bus.Hbusreq   = 4'b0010;
        exp_q.push_back('{m: 2'd1, lock: 1'b0});
        @(negedge clk);
        check("t5b_grant1", 32'(bus.Hgrant), 32'b0010);
        bus.Hbusreq = 4'b0000;
        bus.valid   = 1'b1;
        @(negedge clk);
        check("t5b_beat_beats_withdraw", 32'(bus.Hgrant), 32'b0010);
        @(negedge clk);
        check("t5b_burst_end", 32'(bus.Hgrant), 32'd0);
        bus.valid = 1'b0;

        // Reset mid-burst, then all masters request: master 0 wins first.
        do_reset();
        bus.Hburstlen = 16'h0300;
        bus.valid     = 1'b1;
        bus.Hreadyout = 1'b1;
        bus.Hbusreq   = 4'b0100;
        exp_q.push_back('{m: 2'd2, lock: 1'b0});
        @(negedge clk);
        check("t6_grant2", 32'(bus.Hgrant), 32'b0100);
        @(negedge clk);
        check("t6_mid_burst", 32'(bus.Hmaster), 32'd2);
        Hreset      = 1'b1;
        bus.Hbusreq = 4'b1111;
        @(negedge clk);
        check("t6_rst_grant", 32'(bus.Hgrant), 32'd0);
        check("t6_rst_master", 32'(bus.Hmaster), 32'd0);
        check("t6_rst_busy", 32'(bus.arb_busy), 32'd0);
        check("t6_rst_mastlock", 32'(bus.Hmastlock), 32'd0);
        Hreset = 1'b0;
        exp_q.push_back('{m: 2'd0, lock: 1'b0});
        @(negedge clk);
        check("t6_first_after_rst", 32'(bus.Hgrant), 32'b0001);
        bus.Hbusreq = 4'b0000;
        repeat (4) @(negedge clk);

        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
